// File: rtl/mem_pkg.sv
// ============================================================================
//  Module   : mem_pkg
//  Purpose  : Shared types and constants for the SRAM access controller:
//             controller state encoding, wait-count type, zero-extension widths.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_pkg;

    // CPU-side address width and SRAM address width (zero-extended).
    localparam int unsigned CPU_AW = 16;
    localparam int unsigned MEM_AW = 20;
    localparam int unsigned DATA_W = 16;

    // Wait-state count; wide enough for the 1..15 legal range.
    typedef logic [3:0] wcnt_t;

    // Access controller states.
    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_RD_WAIT    = 3'd1,
        S_RD_CAPTURE = 3'd2,
        S_WR_SETUP   = 3'd3,
        S_WR_PULSE   = 3'd4,
        S_WR_HOLD    = 3'd5,
        S_DONE       = 3'd6
    } state_e;

    // Widen a CPU address onto the SRAM address bus.
    function automatic logic [MEM_AW-1:0] zext_addr(input logic [CPU_AW-1:0] a);
        return {{(MEM_AW-CPU_AW){1'b0}}, a};
    endfunction

endpackage

`default_nettype wire

// File: rtl/wait_state_counter.sv
// ============================================================================
//  Module   : wait_state_counter
//  Purpose  : Loadable 4-bit down-counter with terminal-count flag. Load has
//             priority over count-enable; the counter stops at zero.
//  Ports    : clk_i      - clock
//             rst_ni     - asynchronous active-low reset (count -> 0)
//             load_i     - load load_val_i on the next rising edge
//             load_val_i - value to load
//             en_i       - decrement on the next rising edge
//             tc_o       - high while the count is zero
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wait_state_counter
    import mem_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_ni,
    input  logic  load_i,
    input  wcnt_t load_val_i,
    input  logic  en_i,
    output logic  tc_o
);

    wcnt_t count_q;
    wcnt_t count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && (count_q != wcnt_t'(0))) begin
            count_d = count_q - wcnt_t'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= wcnt_t'(0);
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == wcnt_t'(0));

endmodule

`default_nettype wire

// File: rtl/mem_access_ctrl.sv
// ============================================================================
//  Module   : mem_access_ctrl
//  Purpose  : Sequences 16-bit asynchronous SRAM reads and writes for the CPU.
//             One access at a time; requests seen while busy are dropped.
//  Ports    : Clk, Reset (async, active-low)
//             Req_Read / Req_Write     - access requests (read wins if both)
//             MAR_In / MDR_In          - address / write data from the CPU
//             Mem_Data_In              - SRAM read data
//             ADDR, Mem_Data_Out       - latched SRAM address / write data
//             Mem_Data_OE              - tri-state enable for Mem_Data_Out
//             Data_To_CPU              - last captured read word
//             Mem_CE/OE/WE/UB/LB       - active-low SRAM strobes
//             Ready                    - one-cycle completion pulse
//             Busy                     - high whenever not idle
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int WAIT_STATES = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Req_Read,
    input  logic              Req_Write,
    input  logic [CPU_AW-1:0] MAR_In,
    input  logic [DATA_W-1:0] MDR_In,
    input  logic [DATA_W-1:0] Mem_Data_In,
    output logic [MEM_AW-1:0] ADDR,
    output logic [DATA_W-1:0] Mem_Data_Out,
    output logic              Mem_Data_OE,
    output logic [DATA_W-1:0] Data_To_CPU,
    output logic              Mem_CE,
    output logic              Mem_OE,
    output logic              Mem_WE,
    output logic              Mem_UB,
    output logic              Mem_LB,
    output logic              Ready,
    output logic              Busy
);

    // The counter is loaded with N-1 and the wait state exits on zero,
    // so each wait state spans exactly WAIT_STATES cycles.
    localparam wcnt_t WAIT_LOAD = wcnt_t'(WAIT_STATES - 1);

    state_e            state_q, state_d;
    logic [CPU_AW-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;

    logic cnt_load;
    logic cnt_en;
    logic cnt_tc;
    logic accept;

    wait_state_counter u_wait_cnt (
        .clk_i      (Clk),
        .rst_ni     (Reset),
        .load_i     (cnt_load),
        .load_val_i (WAIT_LOAD),
        .en_i       (cnt_en),
        .tc_o       (cnt_tc)
    );

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        accept   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Req_Read) begin
                    state_d  = S_RD_WAIT;
                    cnt_load = 1'b1;
                    accept   = 1'b1;
                end else if (Req_Write) begin
                    state_d  = S_WR_SETUP;
                    accept   = 1'b1;
                end
            end
            S_RD_WAIT: begin
                if (cnt_tc) begin
                    state_d = S_RD_CAPTURE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            S_RD_CAPTURE: state_d = S_DONE;
            S_WR_SETUP: begin
                state_d  = S_WR_PULSE;
                cnt_load = 1'b1;
            end
            S_WR_PULSE: begin
                if (cnt_tc) begin
                    state_d = S_WR_HOLD;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            S_WR_HOLD: state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            // Address and write data are held from acceptance until the next
            // acceptance, which keeps them stable across the whole access.
            if (accept) begin
                addr_q  <= MAR_In;
                wdata_q <= MDR_In;
            end
            if (state_q == S_RD_CAPTURE) begin
                rdata_q <= Mem_Data_In;
            end
        end
    end

    // Strobes decode straight from the state register so that an
    // asynchronous reset releases them without waiting for a clock.
    always_comb begin
        Mem_CE      = 1'b1;
        Mem_OE      = 1'b1;
        Mem_WE      = 1'b1;
        Mem_Data_OE = 1'b0;
        case (state_q)
            S_RD_WAIT, S_RD_CAPTURE: begin
                Mem_CE = 1'b0;
                Mem_OE = 1'b0;
            end
            S_WR_SETUP, S_WR_HOLD: begin
                Mem_CE      = 1'b0;
                Mem_Data_OE = 1'b1;
            end
            S_WR_PULSE: begin
                Mem_CE      = 1'b0;
                Mem_WE      = 1'b0;
                Mem_Data_OE = 1'b1;
            end
            default: begin
                Mem_CE      = 1'b1;
                Mem_OE      = 1'b1;
                Mem_WE      = 1'b1;
                Mem_Data_OE = 1'b0;
            end
        endcase
    end

    // Byte lanes follow chip enable: 16-bit accesses only.
    assign Mem_UB       = Mem_CE;
    assign Mem_LB       = Mem_CE;
    assign Ready        = (state_q == S_DONE);
    assign Busy         = (state_q != S_IDLE);
    assign ADDR         = zext_addr(addr_q);
    assign Mem_Data_Out = wdata_q;
    assign Data_To_CPU  = rdata_q;

endmodule

`default_nettype wire

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter WAIT_STATES, default 2, SHALL set the SRAM access wait cycles; legal range 1..15.
REQ-002 Clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 Reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 Req_Read  input  1  SHALL request a memory read at the address in MAR_In.
REQ-005 Req_Write  input  1  SHALL request a memory write of MDR_In at the address in MAR_In.
REQ-006 MAR_In  input  16  SHALL carry the address from the MAR register.
REQ-007 MDR_In  input  16  SHALL carry the write data from the MDR register.
REQ-008 Mem_Data_In  input  16  SHALL carry read data from the SRAM bus.
REQ-009 ADDR  output  20  SHALL drive the SRAM address: zero-extended latched address.
REQ-010 Mem_Data_Out  output  16  SHALL carry the latched write data.
REQ-011 Mem_Data_OE  output  1  SHALL enable the top-level tri-state driver; active-high.
REQ-012 Data_To_CPU  output  16  SHALL hold the last captured read word, which feeds the MIO mux.
REQ-013 Mem_CE, Mem_OE, Mem_WE, Mem_UB, Mem_LB  output  1 each  SHALL be the active-low SRAM strobes.
REQ-014 Ready  output  1  SHALL pulse high for one cycle when an access completes.
REQ-015 Busy  output  1  SHALL be high in every state other than IDLE.

Function
REQ-016 States SHALL be IDLE, RD_WAIT, RD_CAPTURE, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
REQ-017 IDLE: Req_Read=1 -> RD_WAIT; else Req_Write=1 -> WR_SETUP; on acceptance, MAR_In and MDR_In SHALL be latched.
REQ-018 If both requests are high in IDLE, the read SHALL win and the write SHALL be dropped.
REQ-019 Requests arriving while Busy=1 SHALL be ignored, not queued.
REQ-020 RD_WAIT SHALL last WAIT_STATES cycles with Mem_CE=0, Mem_OE=0, Mem_WE=1; then -> RD_CAPTURE.
REQ-021 RD_CAPTURE SHALL last 1 cycle with the same strobes; at its closing edge Data_To_CPU <= Mem_Data_In; then -> DONE.
REQ-022 WR_SETUP SHALL last 1 cycle: Mem_CE=0, Mem_WE=1, Mem_OE=1, Mem_Data_OE=1.
REQ-023 WR_PULSE SHALL last WAIT_STATES cycles with Mem_WE=0; all other strobes as in WR_SETUP.
REQ-024 WR_HOLD SHALL last 1 cycle with Mem_WE=1, Mem_CE=0, Mem_Data_OE=1; then -> DONE.
REQ-025 DONE SHALL last 1 cycle with Ready=1 and all strobes inactive; then -> IDLE.
REQ-026 Read latency SHALL be: Ready high WAIT_STATES+2 cycles after the accepting edge. Write latency SHALL be WAIT_STATES+3 cycles.
REQ-027 Mem_UB and Mem_LB SHALL equal Mem_CE, giving 16-bit access only.
REQ-028 ADDR and Mem_Data_Out SHALL stay stable from acceptance until DONE exits.
REQ-029 Data_To_CPU SHALL change only in RD_CAPTURE; writes SHALL not alter it.
REQ-030 In IDLE and DONE, Mem_CE, Mem_OE and Mem_WE SHALL be 1 and Mem_Data_OE SHALL be 0.
REQ-031 Mem_OE=0 and Mem_Data_OE=1 SHALL never both hold in any cycle.

Reset
REQ-032 Reset=0 SHALL immediately force IDLE, including mid-access.
REQ-033 Reset values: all strobes=1, Mem_Data_OE=0, Ready=0, Busy=0, ADDR=0, Mem_Data_Out=0, Data_To_CPU=0, wait counter=0.
REQ-034 An access interrupted by reset SHALL produce no Ready pulse and no Data_To_CPU update.

Structure
REQ-035 Package mem_pkg SHALL hold the state enum, the 4-bit wait-count type and the ZEXT width constants (16, 20).
REQ-036 One sub-module, wait_state_counter, SHALL be used: a loadable 4-bit down-counter with a terminal-count output.

Verification
REQ-037 Read, WAIT_STATES=2, MAR_In=16'h1234, SRAM returns 16'hBEEF -> ADDR=20'h01234, Ready high 4 cycles after acceptance, Data_To_CPU=16'hBEEF.
REQ-038 Write, MAR_In=16'h00FF, MDR_In=16'hA5A5 -> Mem_WE low for exactly 2 cycles, Mem_Data_Out=16'hA5A5 throughout, Ready 5 cycles after acceptance.
REQ-039 Req_Read and Req_Write high together in IDLE -> read sequence only, Mem_WE never low.
REQ-040 Req_Write pulsed during RD_WAIT -> ignored; a single Ready pulse; back to IDLE.
REQ-041 Reset asserted in WR_PULSE -> strobes go to 1 asynchronously, Ready stays 0, Data_To_CPU unchanged.
REQ-042 WAIT_STATES=15 read -> Ready at cycle 17; the assertion Mem_OE=0 with Mem_Data_OE=1 never fires.
